// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage with a prefetch FIFO: keeps up to MAX_OUTSTANDING
// requests in flight on the req/gnt/rvalid bus and hands buffered words to ID.
module if_prefetch_stage #(
  parameter int WORD_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en_i,
  input  logic [WORD_WIDTH-1:0] pc_start_address_i,
  output logic                  instr_req_o,
  output logic [WORD_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i,
  input  logic                  branch_i,
  input  logic [WORD_WIDTH-1:0] branch_target_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [WORD_WIDTH-1:0] instruction_o,
  output logic [WORD_WIDTH-1:0] program_count_o,
  output logic [WORD_WIDTH-1:0] pc_plus4_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [WORD_WIDTH-1:0] WORD_STEP = WORD_WIDTH'(4);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_GNT} fetchState_e;

  fetchState_e state_q, state_d;
  logic [WORD_WIDTH-1:0] fetchAddr_q, fetchAddr_d;
  logic [WORD_WIDTH-1:0] respPc_q, respPc_d;
  logic [WORD_WIDTH-1:0] pendTarget_q, pendTarget_d;
  logic                  staleReq_q, staleReq_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [CNT_W-1:0]      discardCnt_q, discardCnt_d;
  logic [CNT_W-1:0]      fifoCount_q, fifoCount_d;
  logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic [WORD_WIDTH-1:0] fifoInstr_q [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] fifoPc_q    [FIFO_DEPTH];

  logic                  reqGranted, respValid, push, pop, credit;
  logic [WORD_WIDTH-1:0] targetAligned, bootAligned;
  logic [CNT_W:0]        inUse;
  logic                  unusedLowBits;

  assign targetAligned = {branch_target_i[WORD_WIDTH-1:2], 2'b00};
  assign bootAligned   = {pc_start_address_i[WORD_WIDTH-1:2], 2'b00};
  assign unusedLowBits = ^{branch_target_i[1:0], pc_start_address_i[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetchAddr_q   <= bootAligned;
      respPc_q      <= bootAligned;
      pendTarget_q  <= bootAligned;
      staleReq_q    <= 1'b0;
      outstanding_q <= '0;
      discardCnt_q  <= '0;
      fifoCount_q   <= '0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetchAddr_q   <= fetchAddr_d;
      respPc_q      <= respPc_d;
      pendTarget_q  <= pendTarget_d;
      staleReq_q    <= staleReq_d;
      outstanding_q <= outstanding_d;
      discardCnt_q  <= discardCnt_d;
      fifoCount_q   <= fifoCount_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoInstr_q[wrPtr_q] <= instr_rdata_i;
      fifoPc_q[wrPtr_q]    <= respPc_q;
    end
  end

  // Responses with nothing in flight (e.g. left over from before a reset) are ignored.
  always_comb begin
    reqGranted    = instr_req_o & instr_gnt_i;
    respValid     = instr_rvalid_i & (outstanding_q != '0);
    push          = respValid & (discardCnt_q == '0) & ~branch_i;
    pop           = instr_valid_o & instr_ready_i & ~branch_i;
    outstanding_d = outstanding_q + CNT_W'(reqGranted) - CNT_W'(respValid);
    discardCnt_d  = discardCnt_q;
    fifoCount_d   = fifoCount_q + CNT_W'(push) - CNT_W'(pop);
    wrPtr_d       = push ? wrPtr_q + PTR_ONE : wrPtr_q;
    rdPtr_d       = pop ? rdPtr_q + PTR_ONE : rdPtr_q;
    respPc_d      = push ? respPc_q + WORD_STEP : respPc_q;
    fetchAddr_d   = fetchAddr_q;
    staleReq_d    = staleReq_q & ~reqGranted;
    pendTarget_d  = pendTarget_q;
    if (respValid && (discardCnt_q != '0)) discardCnt_d = discardCnt_q - CNT_ONE;
    if (reqGranted) begin
      if (staleReq_q) begin
        discardCnt_d = discardCnt_d + CNT_ONE;
        fetchAddr_d  = pendTarget_q;
      end else begin
        fetchAddr_d  = fetchAddr_q + WORD_STEP;
      end
    end
    // A request still waiting for its grant cannot be retracted, so it is
    // marked stale and the target is parked until that grant arrives.
    if (branch_i) begin
      fifoCount_d  = '0;
      wrPtr_d      = '0;
      rdPtr_d      = '0;
      discardCnt_d = outstanding_d;
      respPc_d     = targetAligned;
      if (instr_req_o && !instr_gnt_i) begin
        staleReq_d   = 1'b1;
        pendTarget_d = targetAligned;
      end else begin
        staleReq_d   = 1'b0;
        fetchAddr_d  = targetAligned;
      end
    end
    inUse  = {1'b0, outstanding_d} + {1'b0, fifoCount_d};
    credit = (inUse < {1'b0, DEPTH_C}) && (outstanding_d < MAX_OUT_C);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:            if (fetch_en_i && credit) state_d = FETCH;
      FETCH, WAIT_GNT: begin
        if (instr_gnt_i) state_d = (fetch_en_i && credit) ? FETCH : IDLE;
        else             state_d = WAIT_GNT;
      end
      default:         state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_req_o     = (state_q == FETCH) || (state_q == WAIT_GNT);
    instr_addr_o    = fetchAddr_q;
    instr_valid_o   = (fifoCount_q != '0);
    instruction_o   = fifoInstr_q[rdPtr_q];
    program_count_o = fifoPc_q[rdPtr_q];
    pc_plus4_o      = program_count_o + WORD_STEP;
    busy_o          = instr_req_o | (outstanding_q != '0);
  end

  always @(posedge clk) begin
    if (rst_n) assert (!(push && (fifoCount_q == DEPTH_C)));
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage with a one-cycle-latency in-order memory model.
module tb_if_prefetch_stage;

  localparam int W = 32;
  localparam logic [W-1:0] PAT = 32'h5A5A_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fetch_en_i;
  logic [W-1:0] pc_start_address_i;
  logic         instr_req_o;
  logic [W-1:0] instr_addr_o;
  logic         instr_gnt_i;
  logic         instr_rvalid_i;
  logic [W-1:0] instr_rdata_i;
  logic         branch_i;
  logic [W-1:0] branch_target_i;
  logic         instr_valid_o;
  logic         instr_ready_i;
  logic [W-1:0] instruction_o;
  logic [W-1:0] program_count_o;
  logic [W-1:0] pc_plus4_o;
  logic         busy_o;

  logic [W-1:0] respQ[$];
  logic         gntEn;
  logic         respEn;
  int           checkCount = 0;
  int           errCount = 0;

  always #5 clk = ~clk;

  if_prefetch_stage #(.WORD_WIDTH(W), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en_i),
    .pc_start_address_i(pc_start_address_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instruction_o(instruction_o), .program_count_o(program_count_o),
    .pc_plus4_o(pc_plus4_o), .busy_o(busy_o)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One clock cycle: handshakes are sampled mid-cycle, the memory model then
  // drives gnt/rvalid/rdata for the next cycle just after the rising edge.
  task automatic applyStimulus();
    logic         granted;
    logic         consumed;
    logic [W-1:0] addr;
    @(negedge clk);
    granted  = instr_req_o & instr_gnt_i;
    consumed = instr_rvalid_i;
    addr     = instr_addr_o;
    @(posedge clk);
    #1;
    if (consumed && respQ.size() > 0) void'(respQ.pop_front());
    if (granted) respQ.push_back(addr);
    instr_gnt_i    = gntEn;
    instr_rvalid_i = respEn && (respQ.size() > 0);
    instr_rdata_i  = (respQ.size() > 0) ? (respQ[0] ^ PAT) : '0;
    #1;
  endtask

  task automatic doReset(input logic [W-1:0] startPc);
    rst_n = 1'b0; pc_start_address_i = startPc;
    fetch_en_i = 1'b0; instr_ready_i = 1'b0; branch_i = 1'b0; branch_target_i = '0;
    gntEn = 1'b1; respEn = 1'b1;
    applyStimulus();
    applyStimulus();
    respQ.delete();
    instr_rvalid_i = 1'b0;
    #1;
    checkOutput("rst_req",   32'(instr_req_o),   32'd0);
    checkOutput("rst_valid", 32'(instr_valid_o), 32'd0);
    checkOutput("rst_busy",  32'(busy_o),        32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; fetch_en_i = 1'b0; pc_start_address_i = '0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0; instr_rdata_i = '0; branch_i = 1'b0; branch_target_i = '0;
    instr_ready_i = 1'b0; gntEn = 1'b1; respEn = 1'b1;

    // Boot streaming from 0x80
    doReset(32'h80);
    fetch_en_i = 1'b1; instr_ready_i = 1'b1;
    applyStimulus();
    checkOutput("boot_req1",  32'(instr_req_o), 32'd1);
    checkOutput("boot_addr1", instr_addr_o, 32'h80);
    applyStimulus();
    checkOutput("boot_addr2",  instr_addr_o, 32'h84);
    checkOutput("boot_valid2", 32'(instr_valid_o), 32'd0);
    applyStimulus();
    checkOutput("boot_valid3", 32'(instr_valid_o), 32'd1);
    checkOutput("boot_pc3",    program_count_o, 32'h80);
    checkOutput("boot_pc4_3",  pc_plus4_o, 32'h84);
    checkOutput("boot_instr3", instruction_o, 32'h5A5A_0080);
    checkOutput("boot_addr3",  instr_addr_o, 32'h88);
    applyStimulus();
    checkOutput("boot_pc4", program_count_o, 32'h84);

    // Backpressure: FIFO fills to 4, one pop allows exactly one more request
    doReset(32'h80);
    fetch_en_i = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus();
    checkOutput("bp_req6",   32'(instr_req_o), 32'd0);
    checkOutput("bp_valid6", 32'(instr_valid_o), 32'd1);
    checkOutput("bp_pc6",    program_count_o, 32'h80);
    applyStimulus();
    checkOutput("bp_req7", 32'(instr_req_o), 32'd0);
    instr_ready_i = 1'b1;
    applyStimulus();
    instr_ready_i = 1'b0;
    checkOutput("bp_req8",  32'(instr_req_o), 32'd1);
    checkOutput("bp_addr8", instr_addr_o, 32'h90);
    checkOutput("bp_pc8",   program_count_o, 32'h84);
    applyStimulus();
    checkOutput("bp_req9", 32'(instr_req_o), 32'd0);
    applyStimulus();
    checkOutput("bp_req10",   32'(instr_req_o), 32'd0);
    checkOutput("bp_valid10", 32'(instr_valid_o), 32'd1);
    instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] expPc;
      expPc = 32'h84 + 32'(4 * i);
      checkOutput("bp_drain_pc", program_count_o, expPc);
      applyStimulus();
    end

    // Grant stall with fetch_en_i dropped while waiting
    doReset(32'h80);
    gntEn = 1'b0; fetch_en_i = 1'b1;
    applyStimulus();
    checkOutput("stall_req1",  32'(instr_req_o), 32'd1);
    checkOutput("stall_addr1", instr_addr_o, 32'h80);
    applyStimulus();
    fetch_en_i = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      checkOutput("stall_req",  32'(instr_req_o), 32'd1);
      checkOutput("stall_addr", instr_addr_o, 32'h80);
      if (i < 5) applyStimulus();
    end
    gntEn = 1'b1;
    applyStimulus();
    checkOutput("stall_req6",  32'(instr_req_o), 32'd1);
    checkOutput("stall_addr6", instr_addr_o, 32'h80);
    applyStimulus();
    checkOutput("stall_req7",  32'(instr_req_o), 32'd0);
    checkOutput("stall_busy7", 32'(busy_o), 32'd1);
    applyStimulus();
    checkOutput("stall_valid8", 32'(instr_valid_o), 32'd1);
    checkOutput("stall_pc8",    program_count_o, 32'h80);
    checkOutput("stall_busy8",  32'(busy_o), 32'd0);

    // Branch flush with two responses in flight and two buffered entries
    doReset(32'h80);
    fetch_en_i = 1'b1;
    applyStimulus(); applyStimulus(); applyStimulus();
    respEn = 1'b0;
    applyStimulus(); applyStimulus();
    checkOutput("br_req5",   32'(instr_req_o), 32'd0);
    checkOutput("br_valid5", 32'(instr_valid_o), 32'd1);
    checkOutput("br_pc5",    program_count_o, 32'h80);
    checkOutput("br_busy5",  32'(busy_o), 32'd1);
    branch_i = 1'b1; branch_target_i = 32'h1002;
    applyStimulus();
    branch_i = 1'b0;
    checkOutput("br_valid6", 32'(instr_valid_o), 32'd0);
    checkOutput("br_req6",   32'(instr_req_o), 32'd0);
    respEn = 1'b1;
    applyStimulus();
    checkOutput("br_valid7", 32'(instr_valid_o), 32'd0);
    applyStimulus();
    checkOutput("br_req8",   32'(instr_req_o), 32'd1);
    checkOutput("br_addr8",  instr_addr_o, 32'h1000);
    checkOutput("br_valid8", 32'(instr_valid_o), 32'd0);
    applyStimulus();
    checkOutput("br_valid9", 32'(instr_valid_o), 32'd0);
    checkOutput("br_addr9",  instr_addr_o, 32'h1004);
    applyStimulus();
    checkOutput("br_valid10", 32'(instr_valid_o), 32'd1);
    checkOutput("br_pc10",    program_count_o, 32'h1000);
    checkOutput("br_instr10", instruction_o, 32'h5A5A_1000);

    // Branch while a request at 0x90 is still ungranted
    doReset(32'h90);
    gntEn = 1'b0; fetch_en_i = 1'b1; instr_ready_i = 1'b1;
    applyStimulus();
    checkOutput("pend_addr1", instr_addr_o, 32'h90);
    applyStimulus();
    branch_i = 1'b1; branch_target_i = 32'h1000;
    applyStimulus();
    branch_i = 1'b0;
    checkOutput("pend_req3",  32'(instr_req_o), 32'd1);
    checkOutput("pend_addr3", instr_addr_o, 32'h90);
    applyStimulus();
    checkOutput("pend_addr4", instr_addr_o, 32'h90);
    gntEn = 1'b1;
    applyStimulus();
    checkOutput("pend_addr5", instr_addr_o, 32'h90);
    applyStimulus();
    checkOutput("pend_addr6",  instr_addr_o, 32'h1000);
    checkOutput("pend_valid6", 32'(instr_valid_o), 32'd0);
    applyStimulus();
    checkOutput("pend_valid7", 32'(instr_valid_o), 32'd0);
    applyStimulus();
    checkOutput("pend_valid8", 32'(instr_valid_o), 32'd1);
    checkOutput("pend_pc8",    program_count_o, 32'h1000);

    // Address wrap, then reset with two responses still in flight
    doReset(32'hFFFF_FFF8);
    fetch_en_i = 1'b1; instr_ready_i = 1'b1;
    applyStimulus();
    checkOutput("wrap_addr1", instr_addr_o, 32'hFFFF_FFF8);
    applyStimulus();
    checkOutput("wrap_addr2", instr_addr_o, 32'hFFFF_FFFC);
    applyStimulus();
    checkOutput("wrap_addr3",  instr_addr_o, 32'h0);
    checkOutput("wrap_pc3",    program_count_o, 32'hFFFF_FFF8);
    checkOutput("wrap_pc4_3",  pc_plus4_o, 32'hFFFF_FFFC);
    respEn = 1'b0;
    applyStimulus();
    checkOutput("wrap_pc4",   program_count_o, 32'hFFFF_FFFC);
    checkOutput("wrap_pc4_4", pc_plus4_o, 32'h0);
    checkOutput("wrap_addr4", instr_addr_o, 32'h4);
    applyStimulus();
    checkOutput("wrap_busy5",  32'(busy_o), 32'd1);
    checkOutput("wrap_valid5", 32'(instr_valid_o), 32'd0);
    rst_n = 1'b0; respEn = 1'b1; fetch_en_i = 1'b0; pc_start_address_i = 32'h200;
    applyStimulus();
    rst_n = 1'b1;
    checkOutput("late_valid6", 32'(instr_valid_o), 32'd0);
    checkOutput("late_req6",   32'(instr_req_o), 32'd0);
    checkOutput("late_busy6",  32'(busy_o), 32'd0);
    applyStimulus();
    checkOutput("late_valid7", 32'(instr_valid_o), 32'd0);
    checkOutput("late_busy7",  32'(busy_o), 32'd0);
    applyStimulus();
    checkOutput("late_valid8", 32'(instr_valid_o), 32'd0);
    fetch_en_i = 1'b1;
    applyStimulus();
    checkOutput("late_req9",  32'(instr_req_o), 32'd1);
    checkOutput("late_addr9", instr_addr_o, 32'h200);
    applyStimulus(); applyStimulus();
    checkOutput("late_valid11", 32'(instr_valid_o), 32'd1);
    checkOutput("late_pc11",    program_count_o, 32'h200);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
